// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: op-code values, arbiter states and default widths.
package alu_arbiter_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 6;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 6'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 6'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND = 6'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 6'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 6'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU-side and response signals of the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int OP_W    = 6,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  // Packed [req][bits] keeps requester i at [i*W +: W] of the flat vector.
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0][OP_W-1:0]   req_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_out;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_zero;
  logic              rsp_neg;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
           rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_neg
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_out, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
           rsp_valid, rsp_data, rsp_id, rsp_zero, rsp_neg
  );
endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_grant wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx
);

  always_comb begin
    int  c;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = int'(last_grant) + k;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!found && req[c]) begin
        found   = 1'b1;
        gnt_idx = c[ID_W-1:0];
      end
    end
    if (found && en) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters, one op in flight,
// results returned over a valid/ready channel tagged with the requester id.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OP_W    = ALU_OP_W,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic              rsp_zero_q, rsp_zero_d, rsp_neg_q, rsp_neg_d;

  logic              accept_en, accept, load;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]   gnt_idx;

  assign accept_en = (state_q == ST_IDLE) || (state_q == ST_RESP && bus.rsp_ready);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .en         (accept_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  // gnt is only ever set for an asserted req_valid, so any grant is an accept.
  assign accept        = |gnt;
  assign bus.req_ready = gnt;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_neg_d    = rsp_neg_q;
    load         = 1'b0;
    case (state_q)
      ST_IDLE: load = accept;
      ST_EXEC: begin
        rsp_data_d  = bus.alu_out;
        rsp_id_d    = grant_id_q;
        rsp_zero_d  = (bus.alu_out == '0);
        rsp_neg_d   = bus.alu_out[DATA_W-1];
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
          load        = accept;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      alu_a_d      = bus.req_a[gnt_idx];
      alu_b_d      = bus.req_b[gnt_idx];
      alu_op_d     = bus.req_op[gnt_idx];
      grant_id_d   = gnt_idx;
      last_grant_d = gnt_idx;
      state_d      = ST_EXEC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_neg_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_neg_q    <= rsp_neg_d;
    end
  end

  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_op    = alu_op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_neg   = rsp_neg_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed scoreboard bench for alu_arbiter with two requesters and a behavioural ALU.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 6;
  localparam int ID_W    = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ID_W(ID_W)) bus ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural ALU sitting on the registered operands.
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  bus.alu_out = bus.alu_a + bus.alu_b;
      OP_SUB:  bus.alu_out = bus.alu_a - bus.alu_b;
      OP_AND:  bus.alu_out = bus.alu_a & bus.alu_b;
      OP_OR:   bus.alu_out = bus.alu_a | bus.alu_b;
      OP_XOR:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = '0;
    endcase
  end

  typedef struct {
    logic [31:0] data;
    logic        id;
    logic        zero;
    logic        neg;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic id, input logic z, input logic n);
    exp_t x;
    x.data = d; x.id = id; x.zero = z; x.neg = n;
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [OP_W-1:0] op);
    bus.req_a[i]  = a;
    bus.req_b[i]  = b;
    bus.req_op[i] = op;
  endtask

  // Monitor: a handshake seen on the falling edge completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rsp actual data=%0h id=%0d required no response", bus.rsp_data, bus.rsp_id);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", bus.rsp_data, e.data);
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
        chk("rsp_neg", 32'(bus.rsp_neg), 32'(e.neg));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;

    // Single request, 2-clock latency
    set_req(0, 32'd5, 32'd3, OP_ADD);
    bus.req_valid = 2'b01;
    #1 chk("t1_req_ready", 32'(bus.req_ready), 32'b01);
    push(32'd8, 1'b0, 1'b0, 1'b0);
    step();
    bus.req_valid = 2'b00;
    chk("t1_alu_a", bus.alu_a, 5);
    chk("t1_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
    chk("t1_valid_exec", 32'(bus.rsp_valid), 0);
    step();
    chk("t1_valid_resp", 32'(bus.rsp_valid), 1);
    chk("t1_rsp_data", bus.rsp_data, 8);
    step();
    chk("t1_valid_idle", 32'(bus.rsp_valid), 0);

    // Round-robin with both requesters held valid from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_req(0, 32'd10, 32'd4, OP_ADD);
    set_req(1, 32'd7, 32'd9, OP_AND);
    bus.req_valid = 2'b11;
    #1 chk("t2_req_ready", 32'(bus.req_ready), 32'b01);
    push(32'd14, 1'b0, 1'b0, 1'b0);
    push(32'd1,  1'b1, 1'b0, 1'b0);
    push(32'd14, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("t2_rsp_cadence", 32'(bus.rsp_valid), (k % 2 == 0) ? 1 : 0);
    end
    bus.req_valid = 2'b00;
    step();
    chk("t2_valid_end", 32'(bus.rsp_valid), 0);

    // Backpressure; zero flag from SUB of equal operands
    bus.rsp_ready = 1'b0;
    set_req(1, 32'h1234, 32'h1234, OP_SUB);
    bus.req_valid = 2'b10;
    push(32'h0, 1'b1, 1'b1, 1'b0);
    step();
    set_req(0, 32'h0, 32'h1, OP_SUB);
    bus.req_valid = 2'b01;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t3_hold_valid", 32'(bus.rsp_valid), 1);
      chk("t3_hold_data", bus.rsp_data, 0);
      chk("t3_hold_id", 32'(bus.rsp_id), 1);
      chk("t3_hold_zero", 32'(bus.rsp_zero), 1);
      chk("t3_req_ready_bp", 32'(bus.req_ready), 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1 chk("t3_req_ready_rel", 32'(bus.req_ready), 32'b01);
    push(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    step();
    bus.req_valid = 2'b00;
    chk("t3_valid_after", 32'(bus.rsp_valid), 0);
    chk("t3_alu_b", bus.alu_b, 1);
    chk("t3_alu_op", 32'(bus.alu_op), 32'(OP_SUB));
    step();
    chk("t3_valid_neg", 32'(bus.rsp_valid), 1);
    step();
    chk("t3_valid_idle", 32'(bus.rsp_valid), 0);

    // Async reset during EXEC discards the op
    set_req(0, 32'h55, 32'h1, OP_ADD);
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = 2'b00;
    chk("t4_alu_a_exec", bus.alu_a, 32'h55);
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_valid", 32'(bus.rsp_valid), 0);
    chk("t4_rst_alu_a", bus.alu_a, 0);
    chk("t4_rst_alu_b", bus.alu_b, 0);
    chk("t4_rst_alu_op", 32'(bus.alu_op), 0);
    step();
    rst = 1'b0;
    step();
    chk("t4_no_rsp1", 32'(bus.rsp_valid), 0);
    step();
    chk("t4_no_rsp2", 32'(bus.rsp_valid), 0);
    set_req(0, 32'd3, 32'd2, OP_SUB);
    set_req(1, 32'd100, 32'd1, OP_ADD);
    bus.req_valid = 2'b11;
    #1 chk("t4_prio_req0", 32'(bus.req_ready), 32'b01);
    push(32'd1, 1'b0, 1'b0, 1'b0);
    step();
    bus.req_valid = 2'b00;
    step();
    chk("t4_valid_resp", 32'(bus.rsp_valid), 1);
    step();

    // Request withdrawn while stalled in RESP is never accepted
    bus.rsp_ready = 1'b0;
    set_req(0, 32'd9, 32'd9, OP_AND);
    bus.req_valid = 2'b01;
    push(32'd9, 1'b0, 1'b0, 1'b0);
    step();
    bus.req_valid = 2'b00;
    step();
    set_req(1, 32'd77, 32'd1, OP_ADD);
    bus.req_valid = 2'b10;
    #1 chk("t5_req_ready_bp", 32'(bus.req_ready), 0);
    step();
    chk("t5_hold_valid", 32'(bus.rsp_valid), 1);
    chk("t5_hold_id", 32'(bus.rsp_id), 0);
    bus.req_valid = 2'b00;
    step();
    bus.rsp_ready = 1'b1;
    step();
    chk("t5_valid_drain", 32'(bus.rsp_valid), 0);
    step();
    chk("t5_no_accept_valid", 32'(bus.rsp_valid), 0);
    chk("t5_no_accept_alu_a", bus.alu_a, 9);
    step();
    chk("t5_no_accept_valid2", 32'(bus.rsp_valid), 0);

    step(); step();
    chk("sb_empty", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between NUM_REQ requesters (e.g. the execute stage and the address-generation unit). It selects requesters round-robin and registers the chosen operands onto the ALU inputs. It then captures the ALU result and returns it, tagged with the requester id, over a valid/ready response channel. One operation is in flight at a time.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, operand/result width
OP_W, 6, ALU operation code width
ID_W, $clog2(NUM_REQ) (min 1), requester id width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
req_valid  input  NUM_REQ  per-requester operation request
req_ready  output  NUM_REQ  one-hot accept strobe, combinational
req_a  input  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  input  NUM_REQ*DATA_W  operand B, same packing
req_op  input  NUM_REQ*OP_W  operation code, requester i at [i*OP_W +: OP_W]
alu_a  output  DATA_W  registered operand A to ALU
alu_b  output  DATA_W  registered operand B to ALU
alu_op  output  OP_W  registered operation to ALU
alu_out  input  DATA_W  ALU combinational result
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_data  output  DATA_W  captured result
rsp_id  output  ID_W  index of requester that issued the op
rsp_zero  output  1  rsp_data == 0
rsp_neg  output  1  rsp_data[DATA_W-1]

Behaviour:
- Reset (async assert):
  - state=IDLE; rsp_valid=0; rsp_data=0; rsp_id=0; rsp_zero=0; rsp_neg=0.
  - alu_a=0, alu_b=0, alu_op=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-operation discards the op; no response is produced.
- Arbitration:
  - Round-robin. Search starts at last_grant+1 (mod NUM_REQ) and the first asserted req_valid wins.
  - last_grant updates only on accept.
- Accept condition: accept_en = (state==IDLE) or (state==RESP and rsp_ready).
  - req_ready[g]=1 only for the winner g, and only when accept_en and any req_valid. Otherwise req_ready=0.
- Accept edge (req_valid[g] & req_ready[g]):
  - alu_a/alu_b/alu_op <= requester g's fields; grant_id <= g; last_grant <= g; state <= EXEC.
- States:
  - IDLE: rsp_valid=0; waits for any req_valid.
  - EXEC: ALU settles on registered operands for one full cycle. At cycle end: rsp_data <= alu_out, rsp_id <= grant_id, rsp_zero/rsp_neg from alu_out, rsp_valid <= 1, state <= RESP.
  - RESP: rsp_valid=1; all rsp_* held stable until rsp_ready.
    - rsp_ready and a new request: accept it (-> EXEC), rsp_valid <= 0.
    - rsp_ready and no request: -> IDLE, rsp_valid <= 0.
    - rsp_ready=0: stay; req_ready=0 (backpressure).
- Latency: accept edge to rsp_valid = 2 clocks. Peak throughput 1 op / 2 clocks with rsp_ready held high.
- alu_* outputs hold their last value outside EXEC; no glitching from requester inputs.
- Requesters must hold a/b/op stable while req_valid is high. Dropping req_valid before req_ready is tolerated: that request is simply not accepted.
- Simultaneous requests: exactly one grant per accept. A requester that stays valid is served within NUM_REQ accepts (no starvation).
- Width rules: no arithmetic in this block. The op code passes unmodified; flags derive from the captured result.

Decomposition:
- alu_pkg: ALU op-code localparams (OP_W-wide), arbiter state enum {IDLE, EXEC, RESP}, DATA_W default.
- Sub-module rr_arbiter (NUM_REQ): inputs req vector, last_grant, enable. Outputs one-hot grant and encoded index. It is purely combinational; the pointer register stays in alu_arbiter.

Test Plan:
- Reset then single request: req_valid=01, a=5, b=3, op=ADD -> req_ready=01 same cycle; rsp_valid 2 clocks later; rsp_data=8, rsp_id=0, zero=0, neg=0.
- Both requesters held valid, rsp_ready=1: three ops complete -> rsp_id sequence 0,1,0; one rsp every 2 clocks.
- Backpressure: rsp_ready=0 for 5 cycles with a pending request -> rsp_data/rsp_id stable, req_ready=0 throughout; rsp_ready=1 -> response consumed and new request accepted same edge.
- Flags: a=b=0x1234 with subtract op -> rsp_zero=1. a=0, b=1 with subtract op -> rsp_data=0xFFFFFFFF, rsp_neg=1.
- Async reset asserted in EXEC -> rsp_valid=0 immediately, alu_*=0. After release, requester 0 wins a simultaneous 11 request.
- Requester drops req_valid while arbiter is in RESP with rsp_ready=0 -> no accept occurs, no spurious response.
